// File: rtl/lcd_char_writer.sv
// HD44780 character-stream front end: power-on wait, init sequence, then ASCII
// bytes become {rs, data} words with cursor tracking and DDRAM address inserts.
module lcd_char_writer #(
  parameter int INIT_WAIT = 1_500_000,
  parameter int COLS      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  output logic [8:0] cmd_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic       init_done_o
);

  localparam int CNT_NEED = $clog2(INIT_WAIT + 1);
  localparam int CNT_W    = (CNT_NEED > 21) ? CNT_NEED : 21;
  localparam logic [CNT_W-1:0] CNT_LAST = (INIT_WAIT > 1) ? CNT_W'(INIT_WAIT - 1) : '0;
  localparam logic [5:0] COL_END = 6'(COLS);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, EMIT_ADDR, EMIT_CHAR, EMIT_CLR
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic             line_q;
  logic [5:0]       col_q;
  logic             wrap_q;
  logic [7:0]       char_q;
  logic [8:0]       cmd_q;
  logic             cmd_valid_q;
  logic             char_ready_q;
  logic             init_done_q;
  logic             accept_d;
  logic             xfer_d;
  logic             printable_d;

  function automatic logic [8:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = 9'h038;
      2'd1:    init_word = 9'h00C;
      2'd2:    init_word = 9'h001;
      default: init_word = 9'h006;
    endcase
  endfunction

  function automatic logic [8:0] addr_word(input logic line);
    addr_word = line ? 9'h0C0 : 9'h080;
  endfunction

  assign accept_d    = char_ready_q & char_valid_i;
  assign xfer_d      = cmd_valid_q & cmd_ready_i;
  assign printable_d = (char_i >= 8'h20) && (char_i <= 8'h7E);

  // Byte is held here so the producer may change char_i right after acceptance.
  always_ff @(posedge clk_i) begin
    if (accept_d) char_q <= char_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= PWR_WAIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      line_q       <= 1'b0;
      col_q        <= '0;
      wrap_q       <= 1'b0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      char_ready_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      case (state_q)
        PWR_WAIT: begin
          if (cnt_q >= CNT_LAST) begin
            state_q <= INIT;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        INIT: begin
          if (!cmd_valid_q) begin
            cmd_q       <= init_word(idx_q);
            cmd_valid_q <= 1'b1;
          end else if (xfer_d) begin
            if (idx_q == 2'd3) begin
              cmd_valid_q  <= 1'b0;
              init_done_q  <= 1'b1;
              line_q       <= 1'b0;
              col_q        <= '0;
              char_ready_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
              cmd_q <= init_word(idx_q + 1'b1);
            end
          end
        end
        IDLE: begin
          if (accept_d) begin
            if (printable_d) begin
              cmd_valid_q  <= 1'b1;
              char_ready_q <= 1'b0;
              if (col_q == COL_END) begin
                wrap_q  <= 1'b1;
                cmd_q   <= addr_word(~line_q);
                state_q <= EMIT_ADDR;
              end else begin
                cmd_q   <= {1'b1, char_i};
                state_q <= EMIT_CHAR;
              end
            end else if (char_i == 8'h0A) begin
              line_q       <= ~line_q;
              col_q        <= '0;
              wrap_q       <= 1'b0;
              cmd_q        <= addr_word(~line_q);
              cmd_valid_q  <= 1'b1;
              char_ready_q <= 1'b0;
              state_q      <= EMIT_ADDR;
            end else if (char_i == 8'h0C) begin
              line_q       <= 1'b0;
              col_q        <= '0;
              cmd_q        <= 9'h001;
              cmd_valid_q  <= 1'b1;
              char_ready_q <= 1'b0;
              state_q      <= EMIT_CLR;
            end
          end
        end
        EMIT_ADDR: begin
          if (xfer_d) begin
            // A wrap address is followed back-to-back by the held character.
            if (wrap_q) begin
              line_q  <= ~line_q;
              col_q   <= '0;
              wrap_q  <= 1'b0;
              cmd_q   <= {1'b1, char_q};
              state_q <= EMIT_CHAR;
            end else begin
              cmd_valid_q  <= 1'b0;
              char_ready_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        EMIT_CHAR: begin
          if (xfer_d) begin
            col_q        <= col_q + 1'b1;
            cmd_valid_q  <= 1'b0;
            char_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        EMIT_CLR: begin
          if (xfer_d) begin
            cmd_valid_q  <= 1'b0;
            char_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

  assign cmd_o        = cmd_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign char_ready_o = char_ready_q;
  assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: directed and random byte streams checked against
// a cursor-level model of the expected LCD word stream.
module tb_lcd_char_writer;

  localparam int INIT_WAIT = 8;
  localparam int COLS      = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] char_i;
  logic       char_valid_i;
  logic       char_ready_o;
  logic [8:0] cmd_o;
  logic       cmd_valid_o;
  logic       cmd_ready_i;
  logic       init_done_o;

  lcd_char_writer #(.INIT_WAIT(INIT_WAIT), .COLS(COLS)) dut (
    .clk_i(clk), .rst_i(rst_i), .char_i(char_i), .char_valid_i(char_valid_i),
    .char_ready_o(char_ready_o), .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] got[$];
  logic [8:0] exp[$];
  logic       mline = 1'b0;
  int         mcol  = 0;
  logic       last_acc = 1'b0;
  logic       rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Expected words from the display rules, tracked as line/column.
  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (mcol == COLS) begin
        mline = !mline;
        mcol  = 0;
        exp.push_back(mline ? 9'h0C0 : 9'h080);
      end
      exp.push_back({1'b1, b});
      mcol++;
    end else if (b == 8'h0A) begin
      mline = !mline;
      mcol  = 0;
      exp.push_back(mline ? 9'h0C0 : 9'h080);
    end else if (b == 8'h0C) begin
      exp.push_back(9'h001);
      mline = 1'b0;
      mcol  = 0;
    end
  endfunction

  task automatic step();
    logic v, r, cr, cv, rs;
    logic [8:0] w;
    v = cmd_valid_o; r = cmd_ready_i; w = cmd_o;
    cr = char_ready_o; cv = char_valid_i; rs = rst_i;
    @(posedge clk);
    #1;
    last_acc = 1'b0;
    if (!rs) begin
      if (v && r) got.push_back(w);
      last_acc = cr && cv;
      if (v && !r) begin
        chk("hold_valid", 32'(cmd_valid_o), 32'd1);
        chk("hold_word", 32'(cmd_o), 32'(w));
      end
    end
    if (rnd_ready) cmd_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] b, output int lowcnt);
    int n;
    char_i = b;
    char_valid_i = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 500);
    chk($sformatf("accept_%02h", b), 32'(last_acc), 32'd1);
    char_valid_i = 1'b0;
    char_i = 8'($urandom);
    model_byte(b);
    lowcnt = 0;
    while (!char_ready_o && lowcnt < 500) begin
      step();
      lowcnt++;
    end
    chk("ready_back", 32'(char_ready_o), 32'd1);
  endtask

  task automatic send_str(input string s);
    int lc;
    for (int i = 0; i < s.len(); i++) send(s[i], lc);
  endtask

  task automatic chk_tail(input string tag, input logic [8:0] want[$]);
    chk({tag, "_len"}, 32'(got.size() >= want.size()), 32'd1);
    if (got.size() >= want.size())
      for (int i = 0; i < want.size(); i++)
        chk($sformatf("%s_%0d", tag, i), 32'(got[got.size() - want.size() + i]), 32'(want[i]));
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    got.delete();
    exp.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, lc, drops;
    logic [8:0] want[$];
    logic [7:0] b;

    rst_i = 1'b1; char_i = 8'h00; char_valid_i = 1'b0; cmd_ready_i = 1'b1;
    repeat (3) step();
    chk("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    chk("rst_cmd", 32'(cmd_o), 32'h000);
    chk("rst_char_ready", 32'(char_ready_o), 32'd0);
    chk("rst_init_done", 32'(init_done_o), 32'd0);

    // Power-on wait and init sequence.
    rst_i = 1'b0;
    exp.push_back(9'h038); exp.push_back(9'h00C); exp.push_back(9'h001); exp.push_back(9'h006);
    first = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (cmd_valid_o && first == 0) first = k;
      chk("init_done_timing", 32'(init_done_o), 32'(got.size() >= 4));
    end
    chk("first_valid_latency", 32'(first), 32'(INIT_WAIT + 1));
    compare_all("init");

    // Two plain characters.
    send(8'h41, lc);
    chk("A_ready_low", 32'(lc), 32'd1);
    send(8'h42, lc);
    chk("B_ready_low", 32'(lc), 32'd1);
    compare_all("ab");

    // Line wrap in both directions.
    send(8'h0C, lc);
    send_str("abcde");
    want = {9'h001, 9'h161, 9'h162, 9'h163, 9'h164, 9'h0C0, 9'h165};
    chk_tail("wrap1", want);
    send_str("fghx");
    want = {9'h080, 9'h178};
    chk_tail("wrap0", want);
    compare_all("wrap");

    // Control bytes.
    send(8'h41, lc); send(8'h0A, lc); send(8'h42, lc); send(8'h0C, lc);
    send(8'h07, lc);
    chk("bell_ready_low", 32'(lc), 32'd0);
    send(8'h43, lc);
    want = {9'h141, 9'h0C0, 9'h142, 9'h001, 9'h143};
    chk_tail("ctrl", want);
    compare_all("ctrl");

    // Back-to-back discarded bytes.
    char_i = 8'h07; char_valid_i = 1'b1; drops = 0;
    repeat (5) begin
      step();
      if (last_acc) drops++;
    end
    char_valid_i = 1'b0;
    chk("drop_rate", 32'(drops), 32'd5);
    chk("drop_no_output", 32'(got.size()), 32'd0);

    // Downstream stall.
    cmd_ready_i = 1'b0; char_i = 8'h41; char_valid_i = 1'b1;
    step();
    chk("stall_accept", 32'(last_acc), 32'd1);
    char_valid_i = 1'b1; char_i = 8'h55;
    model_byte(8'h41);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("stall_valid", 32'(cmd_valid_o), 32'd1);
      chk("stall_word", 32'(cmd_o), 32'h141);
      chk("stall_ready", 32'(char_ready_o), 32'd0);
      chk("stall_no_accept", 32'(last_acc), 32'd0);
    end
    char_valid_i = 1'b0;
    cmd_ready_i = 1'b1;
    step();
    chk("stall_xfer", 32'(got.size()), 32'd1);
    compare_all("stall");

    // Random bytes with random downstream backpressure.
    rnd_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 12)       b = 8'($urandom_range(32'h20, 32'h7E));
      else if (sel < 14)  b = 8'h0A;
      else if (sel == 14) b = 8'h0C;
      else                b = 8'($urandom);
      send(b, lc);
    end
    rnd_ready = 1'b0;
    cmd_ready_i = 1'b1;
    repeat (4) step();
    compare_all("rand");

    // Reset while a wrap address is pending.
    send(8'h0C, lc);
    send_str("abcd");
    compare_all("prewrap");
    cmd_ready_i = 1'b0; char_i = 8'h7A; char_valid_i = 1'b1;
    step();
    char_valid_i = 1'b0;
    chk("wrap_pending_word", 32'(cmd_o), 32'h0C0);
    chk("wrap_pending_valid", 32'(cmd_valid_o), 32'd1);
    rst_i = 1'b1;
    step();
    chk("midrst_valid", 32'(cmd_valid_o), 32'd0);
    chk("midrst_init_done", 32'(init_done_o), 32'd0);
    chk("midrst_char_ready", 32'(char_ready_o), 32'd0);
    got.delete(); exp.delete();
    mline = 1'b0; mcol = 0;
    step();
    rst_i = 1'b0; cmd_ready_i = 1'b1;
    exp.push_back(9'h038); exp.push_back(9'h00C); exp.push_back(9'h001); exp.push_back(9'h006);
    for (int k = 0; k < 100 && !init_done_o; k++) step();
    chk("reinit_done", 32'(init_done_o), 32'd1);
    send(8'h51, lc);
    want = {9'h151};
    chk_tail("after_reset", want);
    compare_all("reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
